// File: rtl/ntt_coeff_serializer_if.sv
// Parallel-beat input / serial coefficient output bundle for ntt_coeff_serializer.
// slave = serializer view, master = upstream/downstream environment view.
interface ntt_coeff_serializer_if #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 64,
  parameter int N_COEFFS             = 2048
);
  localparam int BEATS = N_COEFFS / INPUT_PER_CYCLE;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                            par_valid;
  logic                            par_ready;
  logic [DATA_WIDTH_PER_INPUT-1:0] par_data [INPUT_PER_CYCLE];
  logic                            ser_valid;
  logic                            ser_ready;
  logic [DATA_WIDTH_PER_INPUT-1:0] ser_data;
  logic                            ser_beat_last;
  logic                            ser_frame_last;
  logic [BC_W-1:0]                 beat_count;

  modport master (
    output par_valid, par_data, ser_ready,
    input  par_ready, ser_valid, ser_data, ser_beat_last, ser_frame_last, beat_count
  );

  modport slave (
    input  par_valid, par_data, ser_ready,
    output par_ready, ser_valid, ser_data, ser_beat_last, ser_frame_last, beat_count
  );
endinterface

// File: rtl/ntt_coeff_serializer.sv
// Ping-pong unloader: parallel NTT beats out one coefficient/cycle, first coeff 1 cycle after accept,
// par_ready drops only when both buffers hold beats. NTT_SER_BITREV_EN selects bit-reversed read order.
module ntt_coeff_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 64,
  parameter int N_COEFFS             = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  ntt_coeff_serializer_if.slave  bus
);
  localparam int BEATS = N_COEFFS / INPUT_PER_CYCLE;
  localparam int IDX_W = $clog2(INPUT_PER_CYCLE);
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_PER_CYCLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_par_ready;
  logic                            r_ser_valid;
  logic                            r_beat_last;
  logic                            r_frame_last;
  logic                            r_wr_sel;
  logic                            r_rd_sel;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic [IDX_W-1:0]                w_rd_addr;
  logic [BC_W-1:0]                 r_beat_count;
  logic [BC_W-1:0]                 w_bc_nxt;
  logic                            w_accept;
  logic                            w_take;
  logic                            w_release;
  logic                            w_beat_last_nxt;
  logic [DATA_WIDTH_PER_INPUT-1:0] r_buf [2][INPUT_PER_CYCLE];

  always_comb begin
    w_accept  = bus.par_valid & r_par_ready;
    w_take    = r_ser_valid & bus.ser_ready;
    w_release = w_take & (r_idx == IDX_LAST);

    w_idx_nxt = r_idx;
    if (w_take) begin
      w_idx_nxt = w_release ? '0 : r_idx + 1'b1;
    end

    w_bc_nxt = r_beat_count;
    if (w_release) begin
      w_bc_nxt = (r_beat_count == BC_LAST) ? '0 : r_beat_count + 1'b1;
    end

    // Accept and release in the same cycle leave occupancy unchanged.
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_release)      w_state_nxt = S_FULL;
        else if (!w_accept && w_release) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_release) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase

    w_beat_last_nxt = (w_state_nxt != S_EMPTY) && (w_idx_nxt == IDX_LAST);
  end

  // Flags are computed one cycle ahead so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_par_ready  <= 1'b1;
      r_ser_valid  <= 1'b0;
      r_beat_last  <= 1'b0;
      r_frame_last <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_idx        <= '0;
      r_beat_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_par_ready  <= (w_state_nxt != S_FULL);
      r_ser_valid  <= (w_state_nxt != S_EMPTY);
      r_beat_last  <= w_beat_last_nxt;
      r_frame_last <= w_beat_last_nxt && (w_bc_nxt == BC_LAST);
      r_idx        <= w_idx_nxt;
      r_beat_count <= w_bc_nxt;
      if (w_accept)  r_wr_sel <= ~r_wr_sel;
      if (w_release) r_rd_sel <= ~r_rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
        r_buf[r_wr_sel][i] <= bus.par_data[i];
      end
    end
  end

`ifdef NTT_SER_BITREV_EN
  always_comb begin
    w_rd_addr = '0;
    for (int b = 0; b < IDX_W; b++) begin
      w_rd_addr[b] = r_idx[IDX_W-1-b];
    end
  end
`else
  assign w_rd_addr = r_idx;
`endif

  assign bus.ser_data       = r_buf[r_rd_sel][w_rd_addr];
  assign bus.par_ready      = r_par_ready;
  assign bus.ser_valid      = r_ser_valid;
  assign bus.ser_beat_last  = r_beat_last;
  assign bus.ser_frame_last = r_frame_last;
  assign bus.beat_count     = r_beat_count;
endmodule

// File: tb/tb_ntt_coeff_serializer.sv
// Directed bench for ntt_coeff_serializer; expected read order follows NTT_SER_BITREV_EN.
module tb_ntt_coeff_serializer;
  localparam int DW    = 28;
  localparam int IPC   = 64;
  localparam int NC    = 2048;
  localparam int BEATS = NC / IPC;
  localparam int LOG   = $clog2(IPC);
  localparam int BC_W  = $clog2(BEATS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ntt_coeff_serializer_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N_COEFFS(NC)) bus ();

  ntt_coeff_serializer #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N_COEFFS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int addr(input int k);
    int r;
    r = k;
`ifdef NTT_SER_BITREV_EN
    r = 0;
    for (int i = 0; i < LOG; i++) if (k[i]) r = r | (1 << (LOG - 1 - i));
`endif
    return r;
  endfunction

  task automatic load_beat(input int base);
    for (int i = 0; i < IPC; i++) bus.par_data[i] = DW'(base + i);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.par_valid = 1'b0;
    bus.ser_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_beat(7);
    bus.par_valid = 1'b1;
    step();
    bus.par_valid = 1'b0;
    n_checks++; if (bus.ser_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", bus.ser_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid: got %b want 0", bus.ser_valid); end
    n_checks++; if (bus.par_ready !== 1'b1) begin n_fail++; $display("FAIL reset_par_ready: got %b want 1", bus.par_ready); end
    n_checks++; if (bus.beat_count !== '0) begin n_fail++; $display("FAIL reset_beat_count: got %0d want 0", bus.beat_count); end
    n_checks++; if ({bus.ser_beat_last, bus.ser_frame_last} !== 2'b00) begin n_fail++;
      $display("FAIL reset_last_flags: got %b%b want 00", bus.ser_beat_last, bus.ser_frame_last); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    do_reset();
    load_beat(100);
    bus.par_valid = 1'b1;
    bus.ser_ready = 1'b1;
    step();
    bus.par_valid = 1'b0;
    for (int k = 0; k < IPC; k++) begin
      n_checks++; if (bus.ser_valid !== 1'b1 || bus.ser_data !== DW'(100 + addr(k))) begin n_fail++;
        $display("FAIL single_data[%0d]: got v=%b d=%0d want v=1 d=%0d", k, bus.ser_valid, bus.ser_data, 100 + addr(k)); end
      n_checks++; if (bus.ser_beat_last !== (k == IPC - 1) || bus.ser_frame_last !== 1'b0 || bus.par_ready !== 1'b1) begin n_fail++;
        $display("FAIL single_flags[%0d]: got bl=%b fl=%b pr=%b want bl=%b fl=0 pr=1", k, bus.ser_beat_last,
                 bus.ser_frame_last, bus.par_ready, (k == IPC - 1)); end
      step();
    end
    n_checks++; if (bus.ser_valid !== 1'b0 || bus.beat_count !== BC_W'(1)) begin n_fail++;
      $display("FAIL single_end: got v=%b bc=%0d want v=0 bc=1", bus.ser_valid, bus.beat_count); end
  endtask

  task automatic test_backpressure();
    int base [3];
    base = '{100, 1000, 2000};
    do_reset();
    load_beat(100);
    bus.par_valid = 1'b1;
    step();
    n_checks++; if (bus.par_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_1: got %b want 1", bus.par_ready); end
    load_beat(1000);
    step();
    load_beat(2000);
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (bus.par_ready !== 1'b0 || bus.ser_valid !== 1'b1 || bus.ser_data !== DW'(100 + addr(0))) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got pr=%b v=%b d=%0d want pr=0 v=1 d=%0d", c, bus.par_ready, bus.ser_valid,
                 bus.ser_data, 100 + addr(0)); end
      step();
    end
    bus.ser_ready = 1'b1;
    for (int k = 0; k < 3 * IPC; k++) begin
      n_checks++; if (bus.ser_valid !== 1'b1 || bus.ser_data !== DW'(base[k / IPC] + addr(k % IPC))) begin n_fail++;
        $display("FAIL bp_stream[%0d]: got v=%b d=%0d want v=1 d=%0d", k, bus.ser_valid, bus.ser_data,
                 base[k / IPC] + addr(k % IPC)); end
      n_checks++; if (bus.ser_beat_last !== (k % IPC == IPC - 1) || bus.beat_count !== BC_W'(k / IPC)) begin n_fail++;
        $display("FAIL bp_flags[%0d]: got bl=%b bc=%0d want bl=%b bc=%0d", k, bus.ser_beat_last, bus.beat_count,
                 (k % IPC == IPC - 1), k / IPC); end
      if (k < IPC || k == IPC + 1) begin
        n_checks++; if (bus.par_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low[%0d]: got %b want 0", k, bus.par_ready); end
      end
      if (k == IPC) begin
        n_checks++; if (bus.par_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen: got %b want 1", bus.par_ready); end
      end
      if (k == IPC + 1) bus.par_valid = 1'b0;
      step();
    end
    n_checks++; if (bus.ser_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus.ser_valid); end
    bus.ser_ready = 1'b0;
  endtask

  task automatic test_full_frame();
    int sent, taken, cyc;
    sent = 0; taken = 0; cyc = 0;
    do_reset();
    while (taken < NC && cyc < 20000) begin
      bus.ser_ready = 1'($urandom_range(0, 1));
      bus.par_valid = (sent < BEATS);
      load_beat(sent * IPC);
      #1;
      if (bus.ser_valid) begin
        n_checks++; if (bus.ser_data !== DW'((taken / IPC) * IPC + addr(taken % IPC))) begin n_fail++;
          $display("FAIL frame_data[%0d]: got %0d want %0d", taken, bus.ser_data, (taken / IPC) * IPC + addr(taken % IPC)); end
        n_checks++; if (bus.ser_beat_last !== (taken % IPC == IPC - 1) || bus.ser_frame_last !== (taken == NC - 1)
                        || bus.beat_count !== BC_W'(taken / IPC)) begin n_fail++;
          $display("FAIL frame_flags[%0d]: got bl=%b fl=%b bc=%0d want bl=%b fl=%b bc=%0d", taken, bus.ser_beat_last,
                   bus.ser_frame_last, bus.beat_count, (taken % IPC == IPC - 1), (taken == NC - 1), taken / IPC); end
        if (bus.ser_ready) taken++;
      end else begin
        n_checks++; if (sent * IPC != taken) begin n_fail++;
          $display("FAIL frame_gap: got valid=0 with %0d coeffs taken want %0d", taken, sent * IPC); end
      end
      if (bus.par_valid && bus.par_ready) sent++;
      step();
      cyc++;
    end
    bus.par_valid = 1'b0;
    bus.ser_ready = 1'b0;
    n_checks++; if (taken != NC) begin n_fail++; $display("FAIL frame_timeout: got %0d coeffs want %0d", taken, NC); end
    n_checks++; if (bus.ser_valid !== 1'b0 || bus.beat_count !== '0) begin n_fail++;
      $display("FAIL frame_wrap: got v=%b bc=%0d want v=0 bc=0", bus.ser_valid, bus.beat_count); end
  endtask

  task automatic test_reset_mid_drain();
    int sent, taken, cyc;
    sent = 0; taken = 0; cyc = 0;
    do_reset();
    bus.ser_ready = 1'b1;
    while (taken < 5 * IPC + 30 && cyc < 2000) begin
      bus.par_valid = 1'b1;
      load_beat(sent * IPC);
      #1;
      if (bus.ser_valid) begin
        n_checks++; if (bus.ser_data !== DW'((taken / IPC) * IPC + addr(taken % IPC))) begin n_fail++;
          $display("FAIL middrain_data[%0d]: got %0d want %0d", taken, bus.ser_data, (taken / IPC) * IPC + addr(taken % IPC)); end
        taken++;
      end
      if (bus.par_ready) sent++;
      step();
      cyc++;
    end
    bus.par_valid = 1'b0;
    n_checks++; if (bus.par_ready !== 1'b0 || bus.beat_count !== BC_W'(5) || bus.ser_data !== DW'(5 * IPC + addr(30))) begin n_fail++;
      $display("FAIL middrain_pre: got pr=%b bc=%0d d=%0d want pr=0 bc=5 d=%0d", bus.par_ready, bus.beat_count,
               bus.ser_data, 5 * IPC + addr(30)); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.ser_valid !== 1'b0 || bus.par_ready !== 1'b1 || bus.beat_count !== '0) begin n_fail++;
      $display("FAIL middrain_reset: got v=%b pr=%b bc=%0d want v=0 pr=1 bc=0", bus.ser_valid, bus.par_ready, bus.beat_count); end
    @(negedge clk);
    rst = 1'b0;
    load_beat(5000);
    bus.par_valid = 1'b1;
    step();
    bus.par_valid = 1'b0;
    n_checks++; if (bus.ser_valid !== 1'b1 || bus.ser_data !== DW'(5000 + addr(0)) || bus.beat_count !== '0) begin n_fail++;
      $display("FAIL middrain_restart: got v=%b d=%0d bc=%0d want v=1 d=%0d bc=0", bus.ser_valid, bus.ser_data,
               bus.beat_count, 5000 + addr(0)); end
    bus.ser_ready = 1'b0;
  endtask

  initial begin
    bus.par_valid = 1'b0;
    bus.ser_ready = 1'b0;
    load_beat(0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_full_frame();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
